cycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 141L processor core. It steps each instruction through fetch, decode, execute, memory and writeback. It handshakes with the instruction and data memories and drives the PC, IR and register-file enables. It also maintains a retired-instruction counter and a sticky memory-timeout fault. It sits beside the opcode decoder: the decoder supplies per-instruction control levels, and this block decides *when* those levels take effect.

---
 rtl/cycle_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
// Multi-cycle instruction sequencer. Steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and decides when the control levels
// supplied by the opcode decoder take effect. It also keeps a retired-
// instruction counter and a sticky memory-timeout fault.
//
// Parameters
//   WAIT_LIMIT : memory wait cycles tolerated before faulting (1..255)
//   CNT_W      : width of the retired-instruction counter
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset, clears all state
//   run         in   start request, sampled only in IDLE
//   opcode[3:0] in   opcode of the current IR (valid from DECODE onward)
//   cond        in   branch condition, used in EXEC
//   imem_ready  in   instruction memory has data for imem_req
//   dmem_ready  in   data memory completed dmem_req
//   imem_req    out  instruction fetch request
//   ir_load     out  load IR from instruction memory
//   dmem_req    out  data memory request
//   dmem_we     out  data request is a store
//   reg_write   out  register-file write enable
//   pc_en       out  update PC this cycle
//   pc_sel[1:0] out  PC source: 0 = PC+1, 1 = branch target, 2 = jump target
//   halted      out  core stopped by a halt instruction
//   fault       out  sticky memory-timeout flag
//   retired     out  completed-instruction count (wraps)
//
// Control outputs are decoded combinationally from the registered state and
// the current ready/cond/opcode inputs, so the handshake completes in the
// same cycle that ready is seen.
// -----------------------------------------------------------------------------
module cycle_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_JUMP   = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_HALT   = 4'b1011;

  // Last wait count at which a late ready is still accepted.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_s;

  // Next-state, wait counter and control-output decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;   // zero outside FETCH/MEM, so entry always starts from 0
    retire_s  = 1'b0;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'd0;
    halted    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 8'd1;
          // This wait cycle brings the count to WAIT_LIMIT: give up.
          if (wait_q == WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: begin
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            pc_en    = 1'b1;
            pc_sel   = cond ? 2'd1 : 2'd0;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
          OP_JUMP: begin
            pc_en    = 1'b1;
            pc_sel   = 2'd2;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HALT: begin
            retire_s = 1'b1;
            state_d  = S_HALTED;
          end
          default: begin
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_en    = 1'b1;
            retire_s = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_MEM;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALTED: begin
        halted  = 1'b1;
        state_d = S_HALTED;
      end

      S_FAULT: begin
        fault   = 1'b1;
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired counter next value; wraps naturally at 2^CNT_W.
  always_comb begin
    if (retire_s) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // State, wait counter and retired counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
// Directed self-checking bench for cycle_sequencer. Inputs change 1 ns after
// the rising edge; outputs are compared on the falling edge. A narrow retired
// counter (CNT_W = 8) keeps the wrap-around scenario short.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;

  localparam int WL = 15;
  localparam int CW = 8;

  // Output vector bit order:
  // {imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_en, pc_sel[1:0], halted, fault}
  localparam logic [9:0] O_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] O_FWAIT  = 10'b10_0000_0000;
  localparam logic [9:0] O_FACK   = 10'b11_0000_0000;
  localparam logic [9:0] O_MLD    = 10'b00_1000_0000;
  localparam logic [9:0] O_MST    = 10'b00_1100_0000;
  localparam logic [9:0] O_MSTACK = 10'b00_1101_0000;
  localparam logic [9:0] O_WB     = 10'b00_0011_0000;
  localparam logic [9:0] O_BR1    = 10'b00_0001_0100;
  localparam logic [9:0] O_BR0    = 10'b00_0001_0000;
  localparam logic [9:0] O_JMP    = 10'b00_0001_1000;
  localparam logic [9:0] O_HALT   = 10'b00_0000_0010;
  localparam logic [9:0] O_FAULT  = 10'b00_0000_0001;

  logic          clk = 1'b0;
  logic          reset, run, cond, imem_ready, dmem_ready;
  logic [3:0]    opcode;
  logic          imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_en, halted, fault;
  logic [1:0]    pc_sel;
  logic [CW-1:0] retired;
  logic [9:0]    outs_s;

  int n_vec = 0;
  int n_err = 0;

  cycle_sequencer #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .cond       (cond),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .halted     (halted),
    .fault      (fault),
    .retired    (retired)
  );

  assign outs_s = {imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_en, pc_sel, halted, fault};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE, 1 ns after a rising edge, with all inputs low.
  task automatic do_reset();
    reset = 1'b1; run = 1'b0; cond = 1'b0; opcode = 4'h0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; cond = 1'b0; opcode = 4'h0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_NONE) begin n_err++; $display("FAIL reset_outs got %b want %b", outs_s, O_NONE); end
    n_vec++;
    if (retired !== 8'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired); end
    do_reset();
  endtask

  task automatic test_alu();
    logic [9:0] exp_o [4];
    exp_o = '{O_FACK, O_NONE, O_NONE, O_WB};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b0000;
    tick();
    run = 1'b0;  // run is only sampled in IDLE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (outs_s !== exp_o[i]) begin n_err++; $display("FAIL alu_c%0d got %b want %b", i + 1, outs_s, exp_o[i]); end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd1) begin n_err++; $display("FAIL alu_retired got %0d want 1", retired); end
    n_vec++;
    if (outs_s !== O_FACK) begin n_err++; $display("FAIL alu_refetch got %b want %b", outs_s, O_FACK); end
  endtask

  task automatic test_load_wait();
    logic [9:0] exp_o [8];
    exp_o = '{O_FACK, O_NONE, O_NONE, O_MLD, O_MLD, O_MLD, O_MLD, O_WB};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b0001;
    tick();
    for (int i = 0; i < 8; i++) begin
      dmem_ready = (i == 6);
      @(negedge clk);
      n_vec++;
      if (outs_s !== exp_o[i]) begin n_err++; $display("FAIL load_c%0d got %b want %b", i + 1, outs_s, exp_o[i]); end
      tick();
    end
    dmem_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_FACK) begin n_err++; $display("FAIL load_latency got %b want %b", outs_s, O_FACK); end
    n_vec++;
    if (retired !== 8'd1) begin n_err++; $display("FAIL load_retired got %0d want 1", retired); end
  endtask

  task automatic test_branch();
    logic [9:0] exp_o [6];
    exp_o = '{O_FACK, O_NONE, O_BR1, O_FACK, O_NONE, O_BR0};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b0100;
    tick();
    for (int i = 0; i < 6; i++) begin
      cond = (i < 3);
      @(negedge clk);
      n_vec++;
      if (outs_s !== exp_o[i]) begin n_err++; $display("FAIL branch_c%0d got %b want %b", i + 1, outs_s, exp_o[i]); end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd2) begin n_err++; $display("FAIL branch_retired got %0d want 2", retired); end
  endtask

  // Store followed back to back by a jump, zero wait states.
  task automatic test_back_to_back();
    logic [9:0] exp_o [7];
    logic [3:0] op_v  [7];
    exp_o = '{O_FACK, O_NONE, O_NONE, O_MSTACK, O_FACK, O_NONE, O_JMP};
    op_v  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      opcode = op_v[i];
      @(negedge clk);
      n_vec++;
      if (outs_s !== exp_o[i]) begin n_err++; $display("FAIL b2b_c%0d got %b want %b", i + 1, outs_s, exp_o[i]); end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd2) begin n_err++; $display("FAIL b2b_retired got %0d want 2", retired); end
  endtask

  task automatic test_timeout();
    // Ready on the last tolerated wait count is still accepted.
    do_reset();
    run = 1'b1; opcode = 4'b0000;
    tick();
    for (int i = 0; i < WL; i++) begin
      imem_ready = (i == WL - 1);
      @(negedge clk);
      n_vec++;
      if (outs_s !== ((i == WL - 1) ? O_FACK : O_FWAIT)) begin
        n_err++; $display("FAIL late_ready_c%0d got %b", i + 1, outs_s);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_NONE) begin n_err++; $display("FAIL late_ready_decode got %b want %b", outs_s, O_NONE); end

    // Ready never arrives: fault after WL wait cycles, and it sticks.
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < WL + 3; i++) begin
      imem_ready = (i > WL);
      dmem_ready = (i > WL);
      @(negedge clk);
      n_vec++;
      if (outs_s !== ((i < WL) ? O_FWAIT : O_FAULT)) begin
        n_err++; $display("FAIL timeout_c%0d got %b", i + 1, outs_s);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_NONE) begin n_err++; $display("FAIL fault_cleared got %b want %b", outs_s, O_NONE); end
    tick();
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_NONE) begin n_err++; $display("FAIL idle_after_fault got %b want %b", outs_s, O_NONE); end
  endtask

  task automatic test_halt();
    logic [9:0] exp_o [7];
    exp_o = '{O_FACK, O_NONE, O_NONE, O_HALT, O_HALT, O_HALT, O_HALT};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b1011;
    tick();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_vec++;
      if (outs_s !== exp_o[i]) begin n_err++; $display("FAIL halt_c%0d got %b want %b", i + 1, outs_s, exp_o[i]); end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd1) begin n_err++; $display("FAIL halt_retired got %0d want 1", retired); end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b0000;
    tick();
    repeat (255 * 4) tick();
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd255) begin n_err++; $display("FAIL wrap_max got %0d want 255", retired); end
    tick();
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (retired !== 8'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", retired); end
  endtask

  task automatic test_reset_mem();
    do_reset();
    run = 1'b1; imem_ready = 1'b1; opcode = 4'b0010;
    tick();
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_MST) begin n_err++; $display("FAIL store_mem got %b want %b", outs_s, O_MST); end
    // Reset on the very edge the store would otherwise complete.
    reset = 1'b1; dmem_ready = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (outs_s !== O_NONE) begin n_err++; $display("FAIL mem_reset_outs got %b want %b", outs_s, O_NONE); end
    n_vec++;
    if (retired !== 8'd0) begin n_err++; $display("FAIL mem_reset_retired got %0d want 0", retired); end
    reset = 1'b0; run = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_wrap();
    test_reset_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
